// File: rtl/adc_capture_scheduler.sv
// adc_capture_scheduler: round-robin SPI ADC sweep sequencer filling a ping-pong sample RAM
module adc_capture_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 50000,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 12,
    parameter int TIMEOUT    = 4096
) (
    input  logic              i_ref_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_vsync_pulse,
    input  logic              i_err_clr,
    output logic              o_spi_start,
    output logic [1:0]        o_spi_ch,
    input  logic              i_spi_done,
    input  logic [DATA_W-1:0] i_spi_data,
    output logic              o_wr_en,
    output logic [ADDR_W+2:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_bank,
    output logic              o_frame_ready,
    output logic              o_overrun,
    output logic              o_timeout_err
);
    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [1:0]        CH_LAST   = 2'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, FULL} state_t;

    state_t            r_state, w_next;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [1:0]        r_ch;
    logic [ADDR_W-1:0] r_idx;
    logic              r_wr_bank;
    logic [DATA_W-1:0] r_data;
    logic              r_overrun;
    logic              r_timeout;
    logic              w_tick;
    logic              w_busy;
    logic              w_to_hit;
    logic              w_sweep_end;

    assign w_tick      = i_enable && r_tick_cnt == TICK_LAST;
    assign w_busy      = r_state inside {START, WAIT, WRITE};
    assign w_to_hit    = r_state == WAIT && !i_spi_done && r_to_cnt == TO_LAST;
    assign w_sweep_end = r_ch == CH_LAST;

    // sweep-rate divider: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge i_ref_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_tick_cnt <= '0;
        else            r_tick_cnt <= (!i_enable || w_tick) ? '0 : r_tick_cnt + 1'b1;
    end

    // state register
    always_ff @(posedge i_ref_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // next state and Moore outputs; RAM bus is held at zero outside write cycles
    always_comb begin
        w_next        = r_state;
        o_spi_start   = r_state == START;
        o_spi_ch      = r_ch;
        o_wr_en       = r_state == WRITE;
        o_wr_addr     = o_wr_en ? {r_wr_bank, r_ch, r_idx} : '0;
        o_wr_data     = o_wr_en ? r_data : '0;
        o_rd_bank     = ~r_wr_bank;
        o_frame_ready = r_state == FULL;
        o_overrun     = r_overrun;
        o_timeout_err = r_timeout;
        case (r_state)
            IDLE:    if (w_tick) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (i_spi_done || w_to_hit) w_next = WRITE;
            WRITE:   w_next = !w_sweep_end ? START : (r_idx == IDX_LAST ? FULL : IDLE);
            FULL:    if (i_vsync_pulse) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // channel/index pointers, write bank, abort timer and captured sample
    always_ff @(posedge i_ref_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ch      <= '0;
            r_idx     <= '0;
            r_wr_bank <= 1'b1;
            r_data    <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == START)     r_to_cnt <= '0;
            else if (r_state == WAIT) r_to_cnt <= r_to_cnt + 1'b1;
            if (r_state == WAIT && i_spi_done) r_data <= i_spi_data;
            else if (w_to_hit)                 r_data <= '1;
            if (r_state == WRITE) begin
                r_ch <= w_sweep_end ? 2'd0 : r_ch + 2'd1;
                if (w_sweep_end) r_idx <= r_idx + 1'b1;
            end
            if (r_state == FULL && i_vsync_pulse) r_wr_bank <= ~r_wr_bank;
        end
    end

    // sticky error flags; a new error event outranks a simultaneous clear
    always_ff @(posedge i_ref_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_tick && w_busy) r_overrun <= 1'b1;
            else if (i_err_clr)   r_overrun <= 1'b0;
            if (w_to_hit)         r_timeout <= 1'b1;
            else if (i_err_clr)   r_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_capture_scheduler.sv
// tb_adc_capture_scheduler: ADC responder, event-level reference model, vector table and corner sequences
module tb_adc_capture_scheduler;
    localparam int NCH = 4, DIV = 100, DEP = 4, AW = 2, DW = 12, TO = 50;

    logic          clk = 1'b0;
    logic          rst_n, enable, vsync, err_clr, spi_start, spi_done, wr_en;
    logic          rd_bank, frame_ready, overrun, timeout_err;
    logic [1:0]    spi_ch;
    logic [DW-1:0] spi_data, wr_data;
    logic [AW+2:0] wr_addr;

    int checks = 0, errors = 0;

    int adc_delay = 20, mute_ch = -1, adc_cnt = 0;
    bit rand_delay = 0, rnd = 0, vsync_req = 0, clr_req = 0, clr_on_event = 0;

    int            en_cnt, k, wait_n;
    bit            bank_m, full_m, ov_m, to_m, busy, waiting, exp_start, exp_wr;
    bit            tick, nf, nov, nto, ns, nw, ev;
    logic [DW-1:0] exp_data;
    logic [AW+2:0] exp_addr;

    always #5 clk = ~clk;

    adc_capture_scheduler #(
        .NUM_CH(NCH), .SAMPLE_DIV(DIV), .DEPTH(DEP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .i_ref_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_vsync_pulse(vsync),
        .i_err_clr(err_clr), .o_spi_start(spi_start), .o_spi_ch(spi_ch), .i_spi_done(spi_done),
        .i_spi_data(spi_data), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_rd_bank(rd_bank), .o_frame_ready(frame_ready), .o_overrun(overrun),
        .o_timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // per-cycle process: ADC responder, strobe drivers and reference model
    initial begin
        spi_done = 0; spi_data = '0; vsync = 0; err_clr = 0;
        forever begin
            @(posedge clk);
            #3;
            spi_done = 0; vsync = 0; err_clr = 0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    spi_done = 1;
                    spi_data = DW'($urandom);
                end
            end
            if (spi_start && rst_n)
                adc_cnt = (int'(spi_ch) == mute_ch) ? 0 :
                          rand_delay ? int'($urandom_range(5, 60)) : adc_delay;
            vsync = vsync_req || (rnd && $urandom_range(0, 60) == 0);
            vsync_req = 0;
            ev = waiting && !spi_done && wait_n + 1 == TO;
            err_clr = clr_req || (clr_on_event && ev) || (rnd && $urandom_range(0, 150) == 0);
            clr_req = 0;
            if (!rst_n) begin
                en_cnt = 0; k = 0; bank_m = 1; full_m = 0; ov_m = 0; to_m = 0;
                busy = 0; waiting = 0; exp_start = 0; exp_wr = 0;
            end else begin
                check("frame_ready", frame_ready, full_m);
                check("rd_bank", rd_bank, !bank_m);
                check("overrun", overrun, ov_m);
                check("timeout_err", timeout_err, to_m);
                check("spi_start", spi_start, exp_start);
                check("wr_en", wr_en, exp_wr);
                if (spi_start) check("spi_ch", spi_ch, k % NCH);
                if (wr_en) begin
                    exp_addr = {bank_m, 2'(k % NCH), AW'(k / NCH)};
                    check("wr_addr", wr_addr, exp_addr);
                    check("wr_data", wr_data, exp_data);
                end
                tick = enable && en_cnt == DIV - 1;
                en_cnt = (enable && !tick) ? en_cnt + 1 : 0;
                nf = full_m; ns = 0; nw = 0;
                nov = err_clr ? 0 : ov_m;
                nto = err_clr ? 0 : to_m;
                if (spi_start) begin
                    waiting = 1;
                    wait_n = 0;
                end else if (waiting) begin
                    wait_n++;
                    if (spi_done) begin
                        waiting = 0; nw = 1; exp_data = spi_data;
                    end else if (wait_n == TO) begin
                        waiting = 0; nw = 1; exp_data = '1; nto = 1;
                    end
                end
                if (tick) begin
                    if (busy) nov = 1;
                    else if (!full_m) begin
                        busy = 1; ns = 1;
                    end
                end
                if (wr_en) begin
                    k++;
                    if (k % NCH != 0) ns = 1;
                    else begin
                        busy = 0;
                        if (k == NCH * DEP) nf = 1;
                    end
                end
                if (vsync && full_m) begin
                    bank_m = !bank_m; k = 0; nf = 0;
                end
                full_m = nf; ov_m = nov; to_m = nto; exp_start = ns; exp_wr = nw;
            end
        end
    end

    typedef struct {
        int            off;
        logic          st;
        logic          we;
        logic [1:0]    ch;
        logic [AW+2:0] addr;
    } vec_t;

    vec_t tv[11];

    initial begin
        int n, cnt;
        tv[0]  = '{99,  1'b0, 1'b0, 2'd0, 5'h00};
        tv[1]  = '{100, 1'b1, 1'b0, 2'd0, 5'h00};
        tv[2]  = '{120, 1'b0, 1'b0, 2'd0, 5'h00};
        tv[3]  = '{121, 1'b0, 1'b1, 2'd0, 5'h10};
        tv[4]  = '{122, 1'b1, 1'b0, 2'd1, 5'h00};
        tv[5]  = '{143, 1'b0, 1'b1, 2'd1, 5'h14};
        tv[6]  = '{144, 1'b1, 1'b0, 2'd2, 5'h00};
        tv[7]  = '{165, 1'b0, 1'b1, 2'd2, 5'h18};
        tv[8]  = '{166, 1'b1, 1'b0, 2'd3, 5'h00};
        tv[9]  = '{187, 1'b0, 1'b1, 2'd3, 5'h1C};
        tv[10] = '{188, 1'b0, 1'b0, 2'd0, 5'h00};
        rst_n = 0; enable = 0;
        step(3);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_ch", spi_ch, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_flags", {overrun, timeout_err}, 0);
        rst_n = 1;
        step(2);

        // first sweep timing and addressing from the vector table
        enable = 1;
        n = 0;
        for (int i = 0; i < 11; i++) begin
            while (n < tv[i].off) begin
                step(1);
                n++;
            end
            check($sformatf("tv%0d_start", i), spi_start, tv[i].st);
            check($sformatf("tv%0d_wr_en", i), wr_en, tv[i].we);
            check($sformatf("tv%0d_ch", i), spi_ch, tv[i].ch);
            check($sformatf("tv%0d_addr", i), wr_addr, tv[i].addr);
        end

        // frame fills, then extra ticks are ignored
        n = 0;
        while (!frame_ready && n < 1500) begin step(1); n++; end
        check("frame_full", frame_ready, 1);
        cnt = 0;
        repeat (250) begin
            step(1);
            if (spi_start) cnt++;
        end
        check("full_no_start", cnt, 0);
        check("full_no_overrun", overrun, 0);
        check("full_held", frame_ready, 1);

        // vsync swaps banks, next sweep lands in bank 0
        vsync_req = 1;
        step(1);
        check("swap_rd_bank", rd_bank, 1);
        check("swap_frame_ready", frame_ready, 0);
        n = 0;
        while (!wr_en && n < 300) begin step(1); n++; end
        check("bank0_wr_en", wr_en, 1);
        check("bank0_addr", wr_addr, 5'h00);

        // vsync mid-fill is ignored
        n = 0;
        while (k != 2 * NCH && n < 400) begin step(1); n++; end
        check("midfill_k", k, 2 * NCH);
        vsync_req = 1;
        step(1);
        check("midfill_rd_bank", rd_bank, 1);
        n = 0;
        while (!(wr_en && wr_addr[AW-1:0] == 2'd3) && n < 400) begin step(1); n++; end
        check("midfill_idx3", wr_en, 1);
        check("midfill_bank", wr_addr[AW+2], 0);

        // slow ADC -> overrun; clear afterwards
        n = 0;
        while (!frame_ready && n < 600) begin step(1); n++; end
        vsync_req = 1;
        adc_delay = 150;
        n = 0;
        while (!overrun && n < 800) begin step(1); n++; end
        check("slow_overrun", overrun, 1);
        check("slow_timeout", timeout_err, 1);
        adc_delay = 20;
        step(500);
        clr_req = 1;
        step(2);
        check("clr_overrun", overrun, 0);
        check("clr_timeout", timeout_err, 0);

        // silent ch2 -> timeout, all-ones sample, clear on same cycle loses
        vsync_req = 1;
        mute_ch = 2;
        clr_on_event = 1;
        n = 0;
        while (!timeout_err && n < 600) begin step(1); n++; end
        check("to_flag", timeout_err, 1);
        check("to_wr_en", wr_en, 1);
        check("to_wr_data", wr_data, 12'hFFF);
        check("to_wr_ch", wr_addr[AW+1:AW], 2);
        clr_on_event = 0;
        mute_ch = -1;
        step(1);
        n = 0;
        while (!wr_en && n < 100) begin step(1); n++; end
        check("to_next_ch", wr_addr[AW+1:AW], 3);
        check("to_sticky", timeout_err, 1);

        // reset mid-conversion; late spi_done ignored
        n = 0;
        while (!spi_start && n < 600) begin step(1); n++; end
        step(5);
        rst_n = 0;
        step(1);
        check("mid_rst_outs", {spi_start, wr_en, frame_ready, rd_bank, overrun, timeout_err}, 0);
        enable = 0;
        step(1);
        rst_n = 1;
        cnt = 0;
        repeat (40) begin
            step(1);
            if (wr_en || spi_start) cnt++;
        end
        check("late_done_ignored", cnt, 0);

        // randomized run against the model
        rnd = 1;
        rand_delay = 1;
        enable = 1;
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(50, 300));
            enable = $urandom_range(0, 4) != 0;
        end
        rnd = 0;
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
